// File: rtl/blackjack_round_sequencer_if.sv
// Signal bundle between the round sequencer and its surroundings:
// the user-input debouncers, the card source and the two hand controllers.
interface blackjack_round_sequencer_if #(
   parameter int CARD_W = 4,
   parameter int SUM_W  = 5
);
   logic              i_start;
   logic              i_hit;
   logic              i_stand;
   logic              o_card_req;
   logic              i_card_valid;
   logic [CARD_W-1:0] i_card;
   logic [CARD_W-1:0] o_card;
   logic              o_player_add;
   logic              o_dealer_add;
   logic              o_hand_reset;
   logic [SUM_W-1:0]  i_player_sum;
   logic [2:0]        i_player_count;
   logic [SUM_W-1:0]  i_dealer_sum;
   logic [2:0]        i_dealer_count;
   logic              o_player_turn;
   logic [1:0]        o_result;
   logic              o_done;

   // Sequencer side.
   modport master (
      input  i_start, i_hit, i_stand, i_card_valid, i_card,
             i_player_sum, i_player_count, i_dealer_sum, i_dealer_count,
      output o_card_req, o_card, o_player_add, o_dealer_add, o_hand_reset,
             o_player_turn, o_result, o_done
   );

   // Environment side (inputs, card source, hands).
   modport slave (
      output i_start, i_hit, i_stand, i_card_valid, i_card,
             i_player_sum, i_player_count, i_dealer_sum, i_dealer_count,
      input  o_card_req, o_card, o_player_add, o_dealer_add, o_hand_reset,
             o_player_turn, o_result, o_done
   );
endinterface

// File: rtl/blackjack_round_sequencer.sv
// Blackjack round controller: deals, runs the player and dealer turns and
// scores the round under 5-card Charlie rules.
//
// state  | meaning
// IDLE   | waiting for first start
// CLEAR  | pulse hand reset, clear result and deal counter
// FETCH  | request a card, latch it on valid
// ADD    | one-cycle add pulse to the target hand
// SETTLE | hand sum/count now current; decide what comes next
// PLAYER | waiting for hit or stand
// DEALER | dealer draws below the stand threshold, else compare
// DONE   | result held until next start
module blackjack_round_sequencer #(
   parameter int CARD_W       = 4,
   parameter int SUM_W        = 5,
   parameter int DEALER_STAND = 17,
   parameter int MAX_CARDS    = 5
) (
   input logic i_clk,
   input logic i_reset,
   blackjack_round_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, FETCH, ADD, SETTLE, PLAYER, DEALER, DONE
   } state_t;

   localparam logic [1:0] RES_NONE   = 2'b00;
   localparam logic [1:0] RES_PLAYER = 2'b01;
   localparam logic [1:0] RES_DEALER = 2'b10;
   localparam logic [1:0] RES_PUSH   = 2'b11;

   localparam logic [SUM_W-1:0] SUM_21    = SUM_W'(21);
   localparam logic [SUM_W-1:0] SUM_STAND = SUM_W'(DEALER_STAND);
   localparam logic [2:0]       CNT_MAX   = 3'(MAX_CARDS);

   state_t            state, state_nxt;
   logic              target, target_nxt;   // 0 = player, 1 = dealer
   logic [2:0]        deal_cnt, deal_nxt;
   logic [CARD_W-1:0] card_r, card_nxt;
   logic [1:0]        result_r, result_nxt;

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         target   <= 1'b0;
         deal_cnt <= '0;
         card_r   <= '0;
         result_r <= RES_NONE;
      end else begin
         state    <= state_nxt;
         target   <= target_nxt;
         deal_cnt <= deal_nxt;
         card_r   <= card_nxt;
         result_r <= result_nxt;
      end
   end

   // Next-state and datapath decisions.
   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      deal_nxt   = deal_cnt;
      card_nxt   = card_r;
      result_nxt = result_r;
      case (state)
         IDLE, DONE: begin
            if (bus.i_start) state_nxt = CLEAR;
         end
         CLEAR: begin
            result_nxt = RES_NONE;
            deal_nxt   = '0;
            target_nxt = 1'b0;
            state_nxt  = FETCH;
         end
         FETCH: begin
            if (bus.i_card_valid) begin
               card_nxt  = bus.i_card;
               state_nxt = ADD;
            end
         end
         ADD: state_nxt = SETTLE;
         SETTLE: begin
            if (deal_cnt < 3'd4) begin
               // Deal alternates player/dealer on the counter LSB.
               deal_nxt = deal_cnt + 3'd1;
               if (deal_cnt == 3'd3) begin
                  state_nxt = (bus.i_player_sum == SUM_21) ? DEALER : PLAYER;
               end else begin
                  target_nxt = deal_nxt[0];
                  state_nxt  = FETCH;
               end
            end else if (!target) begin
               if (bus.i_player_sum > SUM_21) begin
                  result_nxt = RES_DEALER;
                  state_nxt  = DONE;
               end else if (bus.i_player_count == CNT_MAX) begin
                  result_nxt = RES_PLAYER;
                  state_nxt  = DONE;
               end else if (bus.i_player_sum == SUM_21) begin
                  state_nxt = DEALER;
               end else begin
                  state_nxt = PLAYER;
               end
            end else begin
               if (bus.i_dealer_sum > SUM_21) begin
                  result_nxt = RES_PLAYER;
                  state_nxt  = DONE;
               end else if (bus.i_dealer_count == CNT_MAX) begin
                  result_nxt = RES_DEALER;
                  state_nxt  = DONE;
               end else begin
                  state_nxt = DEALER;
               end
            end
         end
         PLAYER: begin
            // Stand has priority when both arrive together.
            if (bus.i_stand) begin
               state_nxt = DEALER;
            end else if (bus.i_hit) begin
               target_nxt = 1'b0;
               state_nxt  = FETCH;
            end
         end
         DEALER: begin
            if (bus.i_dealer_sum < SUM_STAND && bus.i_dealer_count < CNT_MAX) begin
               target_nxt = 1'b1;
               state_nxt  = FETCH;
            end else begin
               if (bus.i_player_sum > bus.i_dealer_sum)      result_nxt = RES_PLAYER;
               else if (bus.i_player_sum < bus.i_dealer_sum) result_nxt = RES_DEALER;
               else                                          result_nxt = RES_PUSH;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.o_card_req    = (state == FETCH);
   assign bus.o_player_add  = (state == ADD) && !target;
   assign bus.o_dealer_add  = (state == ADD) && target;
   assign bus.o_hand_reset  = (state == CLEAR);
   assign bus.o_player_turn = (state == PLAYER);
   assign bus.o_done        = (state == DONE);
   assign bus.o_card        = card_r;
   assign bus.o_result      = result_r;

endmodule

// File: tb/tb_blackjack_round_sequencer.sv
// Bench for the blackjack round sequencer: behavioural card source and
// hands, expected add pulses and round results queued by the stimulus and
// checked by an independent monitor.
module tb_blackjack_round_sequencer;
   localparam int CARD_W = 4;
   localparam int SUM_W  = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   blackjack_round_sequencer_if #(.CARD_W(CARD_W), .SUM_W(SUM_W)) bus();

   blackjack_round_sequencer #(
      .CARD_W(CARD_W), .SUM_W(SUM_W), .DEALER_STAND(17), .MAX_CARDS(5)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .bus(bus)
   );

   typedef struct { bit dealer; logic [3:0] v; } add_t;
   typedef struct { logic [1:0] res; int ps; int ds; int pc; int dc; } res_t;

   add_t       add_q[$];
   res_t       res_q[$];
   logic [3:0] card_q[$];

   int tests = 0;
   int fails = 0;
   int src_delay = 0;
   int wait_cnt = 0;
   int xfers = 0;
   int req_cycles = 0;
   int hr_pulses = 0;
   bit done_q = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Behavioural hands: ace counts 11 when that does not bust.
   int p_hard, d_hard, p_cnt, d_cnt;
   bit p_ace, d_ace;

   function automatic int hsum(input int hard, input bit ace);
      return (ace && hard + 10 <= 21) ? hard + 10 : hard;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst || bus.o_hand_reset) begin
         p_hard <= 0; d_hard <= 0; p_cnt <= 0; d_cnt <= 0;
         p_ace <= 1'b0; d_ace <= 1'b0;
      end else begin
         if (bus.o_player_add) begin
            p_hard <= p_hard + int'(bus.o_card);
            p_cnt  <= p_cnt + 1;
            if (bus.o_card == 4'd1) p_ace <= 1'b1;
         end
         if (bus.o_dealer_add) begin
            d_hard <= d_hard + int'(bus.o_card);
            d_cnt  <= d_cnt + 1;
            if (bus.o_card == 4'd1) d_ace <= 1'b1;
         end
      end
   end

   assign bus.i_player_sum   = SUM_W'(hsum(p_hard, p_ace));
   assign bus.i_dealer_sum   = SUM_W'(hsum(d_hard, d_ace));
   assign bus.i_player_count = 3'(p_cnt);
   assign bus.i_dealer_count = 3'(d_cnt);

   // Card source: presents the next queued card after src_delay request cycles.
   always @(negedge clk) begin
      if (bus.o_card_req && card_q.size() > 0) begin
         if (wait_cnt < src_delay) begin
            bus.i_card_valid = 1'b0;
            wait_cnt++;
         end else begin
            bus.i_card_valid = 1'b1;
            bus.i_card       = card_q[0];
         end
      end else begin
         bus.i_card_valid = 1'b0;
      end
   end

   // Transfer bookkeeping at the active edge.
   always @(posedge clk) begin
      if (!rst) begin
         if (bus.o_card_req) req_cycles++;
         if (bus.o_hand_reset) hr_pulses++;
         if (bus.o_card_req && bus.i_card_valid) begin
            void'(card_q.pop_front());
            wait_cnt  = 0;
            src_delay = 0;
            xfers++;
         end
      end
   end

   // Monitor: checks add pulses and round results against the queues.
   always @(negedge clk) begin
      add_t e;
      res_t r;
      if (rst) begin
         done_q = 1'b0;
      end else begin
         if (bus.o_player_add || bus.o_dealer_add) begin
            if (add_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_add: player %0d dealer %0d card %0d, none expected",
                        bus.o_player_add, bus.o_dealer_add, bus.o_card);
            end else begin
               e = add_q.pop_front();
               chk("add_dealer", int'(bus.o_dealer_add), int'(e.dealer));
               chk("add_player", int'(bus.o_player_add), int'(!e.dealer));
               chk("add_card", int'(bus.o_card), int'(e.v));
            end
         end
         if (bus.o_done && !done_q) begin
            if (res_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: result %0d, none expected", bus.o_result);
            end else begin
               r = res_q.pop_front();
               chk("result", int'(bus.o_result), int'(r.res));
               chk("player_sum", int'(bus.i_player_sum), r.ps);
               chk("dealer_sum", int'(bus.i_dealer_sum), r.ds);
               chk("player_count", int'(bus.i_player_count), r.pc);
               chk("dealer_count", int'(bus.i_dealer_count), r.dc);
            end
         end
         done_q = bus.o_done;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // which: 0 start, 1 hit, 2 stand, 3 hit+stand
   task automatic pulse(input int which);
      @(negedge clk);
      bus.i_start = (which == 0);
      bus.i_hit   = (which == 1 || which == 3);
      bus.i_stand = (which == 2 || which == 3);
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_hit   = 1'b0;
      bus.i_stand = 1'b0;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return bus.o_player_turn;
         1:       return bus.o_done;
         default: return bus.o_card_req;
      endcase
   endfunction

   task automatic wait_for(input int which, input string nm);
      int n = 0;
      while (!cond(which) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL timeout_%s: waited %0d cycles, required event never seen", nm, n);
      end
   endtask

   task automatic give(input bit dealer, input logic [3:0] v);
      add_t e;
      e.dealer = dealer;
      e.v      = v;
      card_q.push_back(v);
      add_q.push_back(e);
   endtask

   task automatic deal(input logic [3:0] p1, d1, p2, d2);
      give(1'b0, p1); give(1'b1, d1); give(1'b0, p2); give(1'b1, d2);
   endtask

   task automatic expect_res(input logic [1:0] res, input int ps, ds, pc, dc);
      res_t r;
      r.res = res; r.ps = ps; r.ds = ds; r.pc = pc; r.dc = dc;
      res_q.push_back(r);
   endtask

   task automatic begin_round();
      xfers      = 0;
      req_cycles = 0;
      hr_pulses  = 0;
      pulse(0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_card_req"}, int'(bus.o_card_req), 0);
      chk({tag, "_player_add"}, int'(bus.o_player_add), 0);
      chk({tag, "_dealer_add"}, int'(bus.o_dealer_add), 0);
      chk({tag, "_hand_reset"}, int'(bus.o_hand_reset), 0);
      chk({tag, "_player_turn"}, int'(bus.o_player_turn), 0);
      chk({tag, "_done"}, int'(bus.o_done), 0);
      chk({tag, "_card"}, int'(bus.o_card), 0);
      chk({tag, "_result"}, int'(bus.o_result), 0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_hit   = 1'b0;
      bus.i_stand = 1'b0;
      bus.i_card  = '0;
      tick(2);
      chk_idle_outputs("rst");
      rst = 1'b0;
      tick(2);

      // Player 18 stands, dealer 16 draws a 5 to 21: dealer wins.
      deal(4'd10, 4'd9, 4'd8, 4'd7);
      give(1'b1, 4'd5);
      expect_res(2'b10, 18, 21, 2, 3);
      begin_round();
      wait_for(0, "t1_turn");
      pulse(0);
      chk("t1_start_ignored_turn", int'(bus.o_player_turn), 1);
      chk("t1_hand_reset_pulses", hr_pulses, 1);
      pulse(2);
      wait_for(1, "t1_done");
      chk("t1_transfers", xfers, 5);
      chk("t1_req_cycles", req_cycles, 5);

      // Player 15 hits a 9 and busts at 24; dealer never draws.
      deal(4'd10, 4'd6, 4'd5, 4'd10);
      give(1'b0, 4'd9);
      expect_res(2'b10, 24, 16, 3, 2);
      begin_round();
      wait_for(0, "t2_turn");
      pulse(1);
      wait_for(1, "t2_done");
      tick(10);
      chk("t2_req_cycles", req_cycles, 5);
      chk("t2_done_held", int'(bus.o_done), 1);

      // Five-card Charlie at 11 beats dealer 17.
      deal(4'd2, 4'd10, 4'd2, 4'd7);
      give(1'b0, 4'd2); give(1'b0, 4'd3); give(1'b0, 4'd2);
      expect_res(2'b01, 11, 17, 5, 2);
      begin_round();
      for (int i = 0; i < 3; i++) begin
         wait_for(0, "t3_turn");
         pulse(1);
      end
      wait_for(1, "t3_done");
      chk("t3_transfers", xfers, 7);

      // 18 vs 18, dealer stands at once: push.
      deal(4'd10, 4'd10, 4'd8, 4'd8);
      expect_res(2'b11, 18, 18, 2, 2);
      begin_round();
      wait_for(0, "t4_turn");
      pulse(2);
      wait_for(1, "t4_done");
      chk("t4_transfers", xfers, 4);

      // First deal card held off 3 cycles; then hit+stand together.
      deal(4'd10, 4'd10, 4'd7, 4'd8);
      expect_res(2'b10, 17, 18, 2, 2);
      src_delay = 3;
      begin_round();
      wait_for(0, "t5_turn");
      chk("t5_req_cycles_deal", req_cycles, 7);
      pulse(3);
      wait_for(1, "t5_done");
      chk("t5_transfers", xfers, 4);

      // Reset while the dealer fetch is waiting on the source.
      deal(4'd10, 4'd9, 4'd8, 4'd5);
      begin_round();
      wait_for(0, "t6_turn");
      pulse(2);
      wait_for(2, "t6_dealer_req");
      tick(2);
      chk("t6_req_before_reset", int'(bus.o_card_req), 1);
      #2 rst = 1'b1;
      #1 chk_idle_outputs("t6_abort");
      tick(3);
      rst = 1'b0;
      tick(3);
      chk("t6_no_req_after_reset", int'(bus.o_card_req), 0);

      deal(4'd10, 4'd7, 4'd10, 4'd10);
      expect_res(2'b01, 20, 17, 2, 2);
      begin_round();
      wait_for(0, "t6b_turn");
      chk("t6b_hand_reset_pulses", hr_pulses, 1);
      pulse(2);
      wait_for(1, "t6b_done");
      chk("t6b_transfers", xfers, 4);

      tick(5);
      chk("adds_left", add_q.size(), 0);
      chk("results_left", res_q.size(), 0);
      chk("cards_left", card_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
